// File: rtl/ysyx_22040125_mem_arb.sv
// rtl/ysyx_22040125_mem_arb.sv - round-robin IF/LSU arbiter in front of a single-port RAM
module ysyx_22040125_mem_arb #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [63:0]      if_addr,
   output logic             if_gnt,
   output logic             if_rvalid,
   output logic [31:0]      if_rdata,
   input  logic             lsu_req,
   input  logic             lsu_wen,
   input  logic [63:0]      lsu_addr,
   input  logic [63:0]      lsu_wdata,
   input  logic [7:0]       lsu_wmask,
   output logic             lsu_gnt,
   output logic             lsu_done,
   output logic [63:0]      lsu_rdata,
   output logic             ram_en,
   output logic             ram_wen,
   output logic [31:0]      ram_addr,
   output logic [63:0]      ram_wdata,
   output logic [7:0]       ram_wmask,
   input  logic [63:0]      ram_rdata,
   output logic [CNT_W-1:0] contention_cnt
);

   typedef enum logic [1:0] {
      RESP_NONE,
      RESP_IF,
      RESP_LSU
   } resp_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   resp_t            resp_q;
   resp_t            resp_d;
   logic             last_lsu;   // 1 when the LSU won the most recent grant
   logic             if_a2_q;    // word select for the pending fetch response
   logic             wen_q;      // pending LSU access was a store
   logic [CNT_W-1:0] cnt_q;
   logic             grant_if;
   logic             grant_lsu;
   logic             unused_addr_bits;

   // Only addr[31:3] reaches the RAM; if_addr[2] selects the fetch word.
   assign unused_addr_bits = ^{if_addr[63:32], if_addr[1:0], lsu_addr[63:32], lsu_addr[2:0]};

   // Arbitration: lone requester wins, contention goes to whoever did not win last.
   always_comb begin
      grant_if  = 1'b0;
      grant_lsu = 1'b0;
      if (rst) begin
         if (if_req && lsu_req) begin
            grant_lsu = ~last_lsu;
            grant_if  = last_lsu;
         end else begin
            grant_if  = if_req;
            grant_lsu = lsu_req;
         end
      end
   end

   // RAM request is driven in the grant cycle; idle cycles drive all zeros.
   always_comb begin
      ram_en    = grant_if | grant_lsu;
      ram_wen   = grant_lsu & lsu_wen;
      ram_addr  = 32'd0;
      ram_wdata = 64'd0;
      ram_wmask = 8'd0;
      if (grant_lsu) begin
         ram_addr  = {lsu_addr[31:3], 3'b000};
         ram_wdata = lsu_wdata;
         ram_wmask = lsu_wmask;
      end else if (grant_if) begin
         ram_addr  = {if_addr[31:3], 3'b000};
      end
   end

   // Response FSM next state and one-cycle response outputs.
   always_comb begin
      resp_d    = RESP_NONE;
      if_rvalid = 1'b0;
      if_rdata  = 32'd0;
      lsu_done  = 1'b0;
      lsu_rdata = 64'd0;
      if (grant_lsu) begin
         resp_d = RESP_LSU;
      end else if (grant_if) begin
         resp_d = RESP_IF;
      end
      case (resp_q)
         RESP_IF: begin
            if_rvalid = 1'b1;
            if_rdata  = if_a2_q ? ram_rdata[63:32] : ram_rdata[31:0];
         end
         RESP_LSU: begin
            lsu_done  = 1'b1;
            lsu_rdata = wen_q ? 64'd0 : ram_rdata;
         end
         default: begin
         end
      endcase
   end

   // State registers; reset drops any response still in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         resp_q   <= RESP_NONE;
         last_lsu <= 1'b0;
         if_a2_q  <= 1'b0;
         wen_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         resp_q <= resp_d;
         if (grant_if || grant_lsu) begin
            last_lsu <= grant_lsu;
         end
         if (grant_if) begin
            if_a2_q <= if_addr[2];
         end
         if (grant_lsu) begin
            wen_q <= lsu_wen;
         end
         if (if_req && lsu_req && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   assign if_gnt         = grant_if;
   assign lsu_gnt        = grant_lsu;
   assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_22040125_mem_arb.sv
// tb/tb_ysyx_22040125_mem_arb.sv - scoreboard bench for the IF/LSU memory arbiter
module tb_ysyx_22040125_mem_arb;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        lsu_req;
   logic        lsu_wen;
   logic [63:0] lsu_addr;
   logic [63:0] lsu_wdata;
   logic [7:0]  lsu_wmask;
   logic [63:0] ram_rdata;

   logic        if_gnt, if_rvalid, lsu_gnt, lsu_done, ram_en, ram_wen;
   logic [31:0] if_rdata, ram_addr;
   logic [63:0] lsu_rdata, ram_wdata;
   logic [7:0]  ram_wmask;
   logic [31:0] contention_cnt;

   logic        if_gnt_4, if_rvalid_4, lsu_gnt_4, lsu_done_4, ram_en_4, ram_wen_4;
   logic [31:0] if_rdata_4, ram_addr_4;
   logic [63:0] lsu_rdata_4, ram_wdata_4;
   logic [7:0]  ram_wmask_4;
   logic [3:0]  contention_cnt_4;

   ysyx_22040125_mem_arb dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
      .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wmask(ram_wmask), .ram_rdata(ram_rdata), .contention_cnt(contention_cnt)
   );

   ysyx_22040125_mem_arb #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_4), .if_rvalid(if_rvalid_4), .if_rdata(if_rdata_4),
      .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt_4), .lsu_done(lsu_done_4), .lsu_rdata(lsu_rdata_4),
      .ram_en(ram_en_4), .ram_wen(ram_wen_4), .ram_addr(ram_addr_4), .ram_wdata(ram_wdata_4),
      .ram_wmask(ram_wmask_4), .ram_rdata(ram_rdata), .contention_cnt(contention_cnt_4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: who wins, pending responses, contention count.
   typedef struct {
      int kind;   // 1 = fetch, 2 = load/store
      bit a2;
      bit wen;
   } resp_s;

   resp_s  sb[$];
   bit     m_last_if = 1'b1;
   longint m_cnt     = 0;
   bit     armed     = 1'b0;

   function automatic int winner(input logic r, input logic ir, input logic lr, input bit last_if);
      if (!r) return 0;
      if (ir && lr) return last_if ? 2 : 1;
      if (lr) return 2;
      if (ir) return 1;
      return 0;
   endfunction

   // Model state update at each clock edge.
   always @(posedge clk) begin
      int w;
      resp_s e;
      if (!rst) begin
         m_last_if = 1'b1;
         m_cnt     = 0;
         sb.delete();
         armed     = 1'b1;
      end else if (armed) begin
         w = winner(rst, if_req, lsu_req, m_last_if);
         if (if_req && lsu_req) m_cnt++;
         if (w != 0) begin
            e.kind = w;
            e.a2   = if_addr[2];
            e.wen  = lsu_wen;
            sb.push_back(e);
            m_last_if = (w == 1);
         end
      end
   end

   // Mid-cycle check of the combinational grant/RAM side and counters.
   always @(negedge clk) begin
      int w;
      logic [31:0] ea;
      if (armed) begin
         w  = winner(rst, if_req, lsu_req, m_last_if);
         ea = (w == 2) ? {lsu_addr[31:3], 3'b000} : (w == 1) ? {if_addr[31:3], 3'b000} : 32'd0;
         chk("if_gnt", if_gnt, (w == 1));
         chk("lsu_gnt", lsu_gnt, (w == 2));
         chk("ram_en", ram_en, (w != 0));
         chk("ram_wen", ram_wen, (w == 2) && lsu_wen);
         chk("ram_addr", ram_addr, ea);
         chk("ram_wdata", ram_wdata, (w == 2) ? lsu_wdata : 64'd0);
         chk("ram_wmask", ram_wmask, (w == 2) ? lsu_wmask : 8'd0);
         chk("cnt32", contention_cnt, m_cnt);
         chk("cnt4", contention_cnt_4, (m_cnt > 15) ? 64'd15 : m_cnt);
      end
   end

   // Response monitor: pops the scoreboard in the cycle after each grant.
   always @(negedge clk) begin
      resp_s e;
      if (armed) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 1) begin
               chk("rsp_if_rvalid", if_rvalid, 1);
               chk("rsp_if_rdata", if_rdata, e.a2 ? ram_rdata[63:32] : ram_rdata[31:0]);
               chk("rsp_lsu_done_idle", lsu_done, 0);
               chk("rsp_lsu_rdata_idle", lsu_rdata, 0);
            end else begin
               chk("rsp_lsu_done", lsu_done, 1);
               chk("rsp_lsu_rdata", lsu_rdata, e.wen ? 64'd0 : ram_rdata);
               chk("rsp_if_rvalid_idle", if_rvalid, 0);
               chk("rsp_if_rdata_idle", if_rdata, 0);
            end
         end else begin
            chk("idle_if_rvalid", if_rvalid, 0);
            chk("idle_if_rdata", if_rdata, 0);
            chk("idle_lsu_done", lsu_done, 0);
            chk("idle_lsu_rdata", lsu_rdata, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] seq;
      rst = 1'b0; if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_wen = 1'b0;
      lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; ram_rdata = '0;
      repeat (2) tick();
      rst = 1'b1;

      // Fetch-only read of the upper word
      if_req = 1'b1; if_addr = 64'h80000004; ram_rdata = 64'h11112222_33334444;
      @(negedge clk);
      chk("ifonly_gnt", if_gnt, 1);
      chk("ifonly_addr", ram_addr, 32'h80000000);
      tick(); if_req = 1'b0;
      @(negedge clk);
      chk("ifonly_rvalid", if_rvalid, 1);
      chk("ifonly_rdata", if_rdata, 32'h11112222);
      tick();

      // First contention after reset: LSU wins
      rst = 1'b0; tick(); rst = 1'b1;
      if_req = 1'b1; if_addr = 64'h80000008; lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h80000010;
      @(negedge clk);
      chk("cont_first_lsu_gnt", lsu_gnt, 1);
      chk("cont_first_if_gnt", if_gnt, 0);
      tick(); lsu_req = 1'b0; ram_rdata = 64'h01234567_89ABCDEF;
      @(negedge clk);
      chk("cont_if_gnt", if_gnt, 1);
      chk("cont_lsu_done", lsu_done, 1);
      chk("cont_lsu_rdata", lsu_rdata, 64'h01234567_89ABCDEF);
      tick(); if_req = 1'b0; ram_rdata = 64'hCAFEF00D_12345678;
      @(negedge clk);
      chk("cont_if_rvalid", if_rvalid, 1);
      chk("cont_if_rdata", if_rdata, 32'h12345678);
      chk("cont_cnt", contention_cnt, 1);
      tick();

      // Store
      lsu_req = 1'b1; lsu_wen = 1'b1; lsu_wmask = 8'h0F; lsu_wdata = 64'hDEADBEEF; lsu_addr = 64'h80000020;
      @(negedge clk);
      chk("store_wen", ram_wen, 1);
      chk("store_wmask", ram_wmask, 8'h0F);
      chk("store_wdata", ram_wdata, 64'hDEADBEEF);
      tick(); lsu_req = 1'b0; lsu_wen = 1'b0; ram_rdata = 64'hFFFFFFFF_FFFFFFFF;
      @(negedge clk);
      chk("store_done", lsu_done, 1);
      chk("store_rdata", lsu_rdata, 0);
      tick();

      // Sustained contention alternates starting with LSU
      rst = 1'b0; tick(); rst = 1'b1;
      if_req = 1'b1; lsu_req = 1'b1;
      seq = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seq = {seq[4:0], lsu_gnt};
         tick();
      end
      if_req = 1'b0; lsu_req = 1'b0;
      @(negedge clk);
      chk("alt_seq", seq, 6'b101010);
      chk("alt_cnt", contention_cnt, 6);
      tick();

      // Reset right after a fetch grant drops the response
      rst = 1'b0; tick(); rst = 1'b1;
      if_req = 1'b1; if_addr = 64'h80000104;
      @(negedge clk);
      chk("rstmid_gnt", if_gnt, 1);
      #1 rst = 1'b0; if_req = 1'b0;
      tick();
      @(negedge clk);
      chk("rstmid_rvalid", if_rvalid, 0);
      chk("rstmid_done", lsu_done, 0);
      chk("rstmid_cnt", contention_cnt, 0);
      tick();

      // Saturation of the narrow counter
      rst = 1'b0; tick(); rst = 1'b1;
      if_req = 1'b1; lsu_req = 1'b1;
      repeat (20) tick();
      if_req = 1'b0; lsu_req = 1'b0;
      @(negedge clk);
      chk("sat_cnt4", contention_cnt_4, 15);
      chk("sat_cnt32", contention_cnt, 20);
      tick();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 63) != 0);
         if_req    = ($urandom_range(0, 3) != 0);
         lsu_req   = ($urandom_range(0, 2) != 0);
         lsu_wen   = $urandom_range(0, 1);
         if_addr   = {$urandom, $urandom};
         lsu_addr  = {$urandom, $urandom};
         lsu_wdata = {$urandom, $urandom};
         lsu_wmask = 8'($urandom);
         ram_rdata = {$urandom, $urandom};
         tick();
      end
      rst = 1'b1; if_req = 1'b0; lsu_req = 1'b0;
      repeat (2) tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ysyx_22040125_mem_arb.md
YSYX_22040125_MEM_ARB -- requirements
Module: ysyx_22040125_mem_arb

Interface
REQ-001 SHALL have parameter: CNT_W, default 32, width of the contention counter.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: if_req in 1, if_addr in 64, if_gnt out 1, if_rvalid out 1, if_rdata out 32 (instruction fetch, read-only).
REQ-005 SHALL have ports: lsu_req in 1, lsu_wen in 1, lsu_addr in 64, lsu_wdata in 64, lsu_wmask in 8, lsu_gnt out 1, lsu_done out 1, lsu_rdata out 64 (load/store).
REQ-006 SHALL have ports: ram_en out 1, ram_wen out 1, ram_addr out 32, ram_wdata out 64, ram_wmask out 8, ram_rdata in 64 (single-port RAM, 1-cycle read latency).
REQ-007 SHALL have port: contention_cnt out CNT_W, count of cycles with both requests present.

Function
REQ-008 SHALL grant at most one requester per cycle; gnt combinational in the cycle the request is accepted.
REQ-009 SHALL, on a grant, drive ram_en=1 the same cycle; ram_addr = {winner_addr[31:3],3'b000}; ram_wen = lsu_wen & lsu_gnt; ram_wdata/ram_wmask = lsu_wdata/lsu_wmask on LSU grant, else 0.
REQ-010 SHALL drive ram_en=0, ram_wen=0, ram_addr=0 in cycles with no grant.
REQ-011 SHALL, with a single requester, grant it immediately.
REQ-012 SHALL, with both requesting, grant the one not granted most recently (round-robin); last_winner resets to IF, so LSU wins the first contention.
REQ-013 SHALL update last_winner only on a grant.
REQ-014 SHALL keep response state: RESP_NONE, RESP_IF, RESP_LSU; the next state equals the winner of the current cycle, or RESP_NONE if no grant.
REQ-015 SHALL, in RESP_IF, assert if_rvalid=1 for exactly one cycle with if_rdata = ram_rdata[63:32] if the registered if_addr[2] is 1, else ram_rdata[31:0].
REQ-016 SHALL, in RESP_LSU, assert lsu_done=1 for exactly one cycle; lsu_rdata = ram_rdata for reads and 0 for writes (registered wen).
REQ-017 SHALL allow back-to-back grants: a new grant may coincide with the response cycle of the previous one, giving 1 access per cycle throughput.
REQ-018 SHALL hold if_rdata/lsu_rdata at 0 when the corresponding valid/done is 0.
REQ-019 SHALL treat requesters as holding req and payload stable until gnt; the arbiter does not check this.
REQ-020 SHALL increment contention_cnt by 1 each cycle if_req&lsu_req, saturating at all-ones.
REQ-021 SHALL use only addr[31:3] for RAM addressing; addr[63:32] and lsu_addr[2:0] are ignored.

Reset
REQ-022 SHALL, while rst=0 at a clock edge, set response state to RESP_NONE, last_winner to IF, contention_cnt to 0; all outputs 0 the following cycle.
REQ-023 SHALL suppress gnt and ram_en combinationally while rst=0.
REQ-024 SHALL drop any in-flight response on reset: no if_rvalid/lsu_done after a reset edge for an access granted before it.

Verification
REQ-025 SHALL test IF-only read: if_req=1, if_addr=0x80000004, ram_rdata=0x11112222_33334444 -> if_gnt same cycle, ram_addr=0x80000000; next cycle if_rvalid=1, if_rdata=0x11112222.
REQ-026 SHALL test first contention after reset: both req, LSU read 0x80000010 -> lsu_gnt first; next cycle if_gnt plus lsu_done with lsu_rdata=ram_rdata; the cycle after, if_rvalid; contention_cnt=1.
REQ-027 SHALL test LSU store: lsu_wen=1, lsu_wmask=0x0F, lsu_wdata=0xDEADBEEF -> ram_wen=1, ram_wmask=0x0F same cycle; next cycle lsu_done=1, lsu_rdata=0.
REQ-028 SHALL test sustained contention for 6 cycles -> grants alternate LSU, IF, LSU, IF, LSU, IF; contention_cnt=6.
REQ-029 SHALL test reset mid-access: grant IF, assert rst=0 the next edge -> if_rvalid never asserted; all outputs 0; contention_cnt=0.
REQ-030 SHALL test counter saturation with CNT_W=4: 20 contention cycles -> contention_cnt=15.
